// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every input vector through the circuit under test and compares its truth table.
// busy_o and done_o are registered decodes of the current state, so done_o pulses on the edge that leaves DONE.
module truth_table_sequencer #(
    parameter int               N_IN     = 3,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'h46,
    parameter int               SETTLE   = 2,
    parameter int               CW       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 z_in_i,
    output logic [N_IN-1:0]      x_out_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [2**N_IN-1:0]   table_out_o,
    output logic                 fail_valid_o,
    output logic [N_IN-1:0]      fail_idx_o
);
    localparam int NV = 2**N_IN;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE == 0 ? 0 : SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d, x_q, x_d, fi_q, fi_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NV-1:0]   tbl_q, tbl_d;
    logic            pass_q, pass_d, fv_q, fv_d, busy_q, busy_d, done_q, done_d;
    logic            active, go, clr;

    always_comb begin
        active  = (state_q == WAIT) || (state_q == SAMPLE);
        go      = (state_q == IDLE) && start_i && !abort_i;
        clr     = go || (active && abort_i);
        state_d = state_q;
        idx_d   = clr ? '0 : idx_q;
        x_d     = clr ? '0 : x_q;
        cnt_d   = clr ? '0 : cnt_q;
        tbl_d   = clr ? '0 : tbl_q;
        pass_d  = clr ? 1'b0 : pass_q;
        fv_d    = clr ? 1'b0 : fv_q;
        fi_d    = clr ? '0 : fi_q;
        case (state_q)
            IDLE:    state_d = go ? ((SETTLE == 0) ? SAMPLE : WAIT) : IDLE;
            WAIT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    tbl_d[idx_q] = z_in_i;
                    if ((z_in_i != EXPECTED[idx_q]) && !fv_q) begin
                        fv_d = 1'b1;
                        fi_d = idx_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        pass_d  = (tbl_d == EXPECTED);
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        x_d     = idx_q + 1'b1;
                        state_d = (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                end
            end
            DONE: begin
                x_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // an abort drops busy on the same edge that returns to IDLE
        busy_d = active && (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
            fi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            fi_q    <= fi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_out_o      = x_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign table_out_o  = tbl_q;
    assign fail_valid_o = fv_q;
    assign fail_idx_o   = fi_q;
endmodule
